// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute over a shared ALU and memory.
// Optional: define ILLEGAL_TRAP_EN to trap on unlisted opcodes and raise illegal_o.
module multicycle_control_fsm #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic             clk_i,
  input  logic             rstN_i,
  input  logic [6:0]       op_i,
  input  logic             memReady_i,
  output logic [3:0]       state_o,
  output logic             pcWrite_o,
  output logic             irWrite_o,
  output logic             adrSrc_o,
  output logic             memRead_o,
  output logic             memWrite_o,
  output logic             regWrite_o,
  output logic [1:0]       aluSrcA_o,
  output logic [1:0]       aluSrcB_o,
  output logic [1:0]       aluOp_o,
  output logic [1:0]       resultSrc_o,
  output logic [2:0]       immSrc_o,
  output logic [1:0]       branch_o,
  output logic             instrRetired_o,
  output logic [CNT_W-1:0] retireCount_o,
  output logic             memErr_o,
  output logic             illegal_o
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 2);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECR    = 4'd7,
    S_EXECI    = 4'd8,
    S_ALUWB    = 4'd9,
    S_BRANCH   = 4'd10,
    S_JAL      = 4'd11,
    S_JALR     = 4'd12,
    S_JALRLINK = 4'd13,
    S_LUI      = 4'd14,
    S_TRAP     = 4'd15
  } state_t;

`ifdef ILLEGAL_TRAP_EN
  localparam state_t S_ILLEGAL = S_TRAP;
`else
  localparam state_t S_ILLEGAL = S_FETCH;
`endif

  state_t            r_state;
  state_t            w_next;
  logic [WAIT_W-1:0] r_wait;
  logic [CNT_W-1:0]  r_count;
  logic              r_mem_err;
  logic              w_wait_st;
  logic              w_timeout;
  logic              w_op_legal;

  assign w_wait_st = (r_state == S_FETCH) || (r_state == S_MEMREAD) || (r_state == S_MEMWRITE);
  assign w_timeout = (MEM_TIMEOUT != 0) && w_wait_st && !memReady_i &&
                     (r_wait == WAIT_W'(MEM_TIMEOUT));
  assign w_op_legal = (op_i == OP_LOAD) || (op_i == OP_STORE) || (op_i == OP_R) ||
                      (op_i == OP_I) || (op_i == OP_BR) || (op_i == OP_JAL) ||
                      (op_i == OP_JALR) || (op_i == OP_LUI);

  // Next-state logic; ready in a wait state always beats the timeout.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     w_next = S_FETCH;
      S_FETCH:    if (memReady_i) w_next = S_DECODE;
                  else if (w_timeout) w_next = S_TRAP;
      S_DECODE: begin
        if (!w_op_legal) w_next = S_ILLEGAL;
        else if (op_i == OP_LOAD || op_i == OP_STORE) w_next = S_MEMADR;
        else if (op_i == OP_R) w_next = S_EXECR;
        else if (op_i == OP_I) w_next = S_EXECI;
        else if (op_i == OP_BR) w_next = S_BRANCH;
        else if (op_i == OP_JAL) w_next = S_JAL;
        else if (op_i == OP_JALR) w_next = S_JALR;
        else w_next = S_LUI;
      end
      S_MEMADR:   w_next = (op_i == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (memReady_i) w_next = S_MEMWB;
                  else if (w_timeout) w_next = S_TRAP;
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: if (memReady_i) w_next = S_FETCH;
                  else if (w_timeout) w_next = S_TRAP;
      S_EXECR:    w_next = S_ALUWB;
      S_EXECI:    w_next = S_ALUWB;
      S_ALUWB:    w_next = S_FETCH;
      S_BRANCH:   w_next = S_FETCH;
      S_JAL:      w_next = S_ALUWB;
      S_JALR:     w_next = S_JALRLINK;
      S_JALRLINK: w_next = S_ALUWB;
      S_LUI:      w_next = S_FETCH;
      S_TRAP:     w_next = S_TRAP;
      default:    w_next = S_IDLE;
    endcase
  end

  // State, wait counter, retire counter and sticky error flag.
  always_ff @(posedge clk_i or negedge rstN_i) begin
    if (!rstN_i) begin
      r_state   <= S_IDLE;
      r_wait    <= '0;
      r_count   <= '0;
      r_mem_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_wait_st && !memReady_i && (w_next == r_state)) begin
        if (r_wait != '1) r_wait <= r_wait + WAIT_W'(1);
      end else begin
        r_wait <= '0;
      end
      if (instrRetired_o) r_count <= r_count + CNT_W'(1);
      if (w_timeout) r_mem_err <= 1'b1;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic r_illegal;

  always_ff @(posedge clk_i or negedge rstN_i) begin
    if (!rstN_i) r_illegal <= 1'b0;
    else if (r_state == S_DECODE && !w_op_legal) r_illegal <= 1'b1;
  end

  assign illegal_o = r_illegal;
`else
  assign illegal_o = 1'b0;
`endif

  assign state_o       = r_state;
  assign retireCount_o = r_count;
  assign memErr_o      = r_mem_err;

  // Moore decode of datapath controls; FETCH strobes and MEMWRITE retire follow memReady_i.
  always_comb begin
    pcWrite_o      = 1'b0;
    irWrite_o      = 1'b0;
    adrSrc_o       = 1'b0;
    memRead_o      = 1'b0;
    memWrite_o     = 1'b0;
    regWrite_o     = 1'b0;
    aluSrcA_o      = 2'b00;
    aluSrcB_o      = 2'b00;
    aluOp_o        = 2'b00;
    resultSrc_o    = 2'b00;
    immSrc_o       = 3'b000;
    branch_o       = 2'b00;
    instrRetired_o = 1'b0;
    case (r_state)
      S_FETCH: begin
        memRead_o   = 1'b1;
        aluSrcB_o   = 2'b10;
        resultSrc_o = 2'b10;
        irWrite_o   = memReady_i;
        pcWrite_o   = memReady_i;
      end
      S_DECODE: begin
        aluSrcA_o = 2'b01;
        aluSrcB_o = 2'b01;
        case (op_i)
          OP_STORE: immSrc_o = 3'b001;
          OP_BR:    immSrc_o = 3'b010;
          OP_JAL:   immSrc_o = 3'b011;
          OP_LUI:   immSrc_o = 3'b100;
          default:  immSrc_o = 3'b000;
        endcase
      end
      S_MEMADR: begin
        aluSrcA_o = 2'b10;
        aluSrcB_o = 2'b01;
        immSrc_o  = (op_i == OP_STORE) ? 3'b001 : 3'b000;
      end
      S_MEMREAD: begin
        adrSrc_o  = 1'b1;
        memRead_o = 1'b1;
      end
      S_MEMWB: begin
        resultSrc_o    = 2'b01;
        regWrite_o     = 1'b1;
        instrRetired_o = 1'b1;
      end
      S_MEMWRITE: begin
        adrSrc_o       = 1'b1;
        memWrite_o     = 1'b1;
        instrRetired_o = memReady_i;
      end
      S_EXECR: begin
        aluSrcA_o = 2'b10;
        aluOp_o   = 2'b10;
      end
      S_EXECI: begin
        aluSrcA_o = 2'b10;
        aluSrcB_o = 2'b01;
        aluOp_o   = 2'b10;
      end
      S_ALUWB: begin
        regWrite_o     = 1'b1;
        instrRetired_o = 1'b1;
      end
      S_BRANCH: begin
        aluSrcA_o      = 2'b10;
        aluOp_o        = 2'b01;
        branch_o       = 2'b01;
        immSrc_o       = 3'b010;
        instrRetired_o = 1'b1;
      end
      S_JAL: begin
        pcWrite_o = 1'b1;
        branch_o  = 2'b10;
        aluSrcA_o = 2'b01;
        aluSrcB_o = 2'b10;
        immSrc_o  = 3'b011;
      end
      S_JALR: begin
        aluSrcA_o   = 2'b10;
        aluSrcB_o   = 2'b01;
        resultSrc_o = 2'b10;
        pcWrite_o   = 1'b1;
        branch_o    = 2'b11;
      end
      S_JALRLINK: begin
        aluSrcA_o = 2'b01;
        aluSrcB_o = 2'b10;
      end
      S_LUI: begin
        immSrc_o       = 3'b100;
        resultSrc_o    = 2'b11;
        regWrite_o     = 1'b1;
        instrRetired_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed table-driven bench for multicycle_control_fsm (CNT_W=4, MEM_TIMEOUT=4).
module tb_multicycle_control_fsm;

  localparam int unsigned CNT_W = 4;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_BAD   = 7'b1111111;

  logic clk_i = 1'b0;
  logic rstN_i = 1'b0;
  logic [6:0] op_i = OP_R;
  logic memReady_i = 1'b0;
  logic [3:0] state_o;
  logic pcWrite_o, irWrite_o, adrSrc_o, memRead_o, memWrite_o, regWrite_o;
  logic [1:0] aluSrcA_o, aluSrcB_o, aluOp_o, resultSrc_o, branch_o;
  logic [2:0] immSrc_o;
  logic instrRetired_o, memErr_o, illegal_o;
  logic [CNT_W-1:0] retireCount_o;

  multicycle_control_fsm #(.CNT_W(CNT_W), .MEM_TIMEOUT(4)) dut (
    .clk_i(clk_i), .rstN_i(rstN_i), .op_i(op_i), .memReady_i(memReady_i),
    .state_o(state_o), .pcWrite_o(pcWrite_o), .irWrite_o(irWrite_o),
    .adrSrc_o(adrSrc_o), .memRead_o(memRead_o), .memWrite_o(memWrite_o),
    .regWrite_o(regWrite_o), .aluSrcA_o(aluSrcA_o), .aluSrcB_o(aluSrcB_o),
    .aluOp_o(aluOp_o), .resultSrc_o(resultSrc_o), .immSrc_o(immSrc_o),
    .branch_o(branch_o), .instrRetired_o(instrRetired_o),
    .retireCount_o(retireCount_o), .memErr_o(memErr_o), .illegal_o(illegal_o)
  );

  always #5 clk_i = ~clk_i;

  wire [19:0] act_ctl = {pcWrite_o, irWrite_o, adrSrc_o, memRead_o, memWrite_o, regWrite_o,
                         aluSrcA_o, aluSrcB_o, aluOp_o, resultSrc_o, immSrc_o, branch_o,
                         instrRetired_o};

  typedef struct {
    logic [6:0]       op;
    logic             rdy;
    logic [3:0]       st;
    logic [19:0]      ctl;
    logic [CNT_W-1:0] cnt;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [19:0] ctl(input logic pcw, input logic irw, input logic adr,
                                      input logic mr, input logic mw, input logic rw,
                                      input logic [1:0] a, input logic [1:0] b,
                                      input logic [1:0] aop, input logic [1:0] res,
                                      input logic [2:0] imm, input logic [1:0] br,
                                      input logic ret);
    return {pcw, irw, adr, mr, mw, rw, a, b, aop, res, imm, br, ret};
  endfunction

  function automatic vec_t mk(input logic [6:0] op, input logic rdy, input logic [3:0] st,
                              input logic [19:0] c, input int cnt);
    vec_t v;
    v.op = op; v.rdy = rdy; v.st = st; v.ctl = c; v.cnt = CNT_W'(cnt);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [6:0] op, input logic rdy);
    op_i = op;
    memReady_i = rdy;
    #2;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rstN_i = 1'b0;
    op_i = OP_R;
    memReady_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_ctl", 32'(act_ctl), 32'd0);
    chk("rst_cnt", 32'(retireCount_o), 32'd0);
    chk("rst_flags", {30'd0, memErr_o, illegal_o}, 32'd0);
    rstN_i = 1'b1;
  endtask

  logic [19:0] K_F0, K_F1, K_MRD, K_MWB, K_MWR0, K_MWR1, K_EXR, K_EXI, K_AWB;
  logic [19:0] K_BR, K_JAL, K_JALR, K_JLNK, K_LUI;

  function automatic logic [19:0] k_dec(input logic [2:0] imm);
    return ctl(0,0,0,0,0,0,2'b01,2'b01,2'b00,2'b00,imm,2'b00,0);
  endfunction

  function automatic logic [19:0] k_madr(input logic [2:0] imm);
    return ctl(0,0,0,0,0,0,2'b10,2'b01,2'b00,2'b00,imm,2'b00,0);
  endfunction

  initial begin
    K_F0   = ctl(0,0,0,1,0,0,2'b00,2'b10,2'b00,2'b10,3'b000,2'b00,0);
    K_F1   = ctl(1,1,0,1,0,0,2'b00,2'b10,2'b00,2'b10,3'b000,2'b00,0);
    K_MRD  = ctl(0,0,1,1,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,2'b00,0);
    K_MWB  = ctl(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b01,3'b000,2'b00,1);
    K_MWR0 = ctl(0,0,1,0,1,0,2'b00,2'b00,2'b00,2'b00,3'b000,2'b00,0);
    K_MWR1 = ctl(0,0,1,0,1,0,2'b00,2'b00,2'b00,2'b00,3'b000,2'b00,1);
    K_EXR  = ctl(0,0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,2'b00,0);
    K_EXI  = ctl(0,0,0,0,0,0,2'b10,2'b01,2'b10,2'b00,3'b000,2'b00,0);
    K_AWB  = ctl(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,2'b00,1);
    K_BR   = ctl(0,0,0,0,0,0,2'b10,2'b00,2'b01,2'b00,3'b010,2'b01,1);
    K_JAL  = ctl(1,0,0,0,0,0,2'b01,2'b10,2'b00,2'b00,3'b011,2'b10,0);
    K_JALR = ctl(1,0,0,0,0,0,2'b10,2'b01,2'b00,2'b10,3'b000,2'b11,0);
    K_JLNK = ctl(0,0,0,0,0,0,2'b01,2'b10,2'b00,2'b00,3'b000,2'b00,0);
    K_LUI  = ctl(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b11,3'b100,2'b00,1);

    // R-type, I-ALU, load with 3 wait cycles, store with 1, branch, JAL, JALR, LUI, illegal
    vecs.push_back(mk(OP_R, 1, 0, 20'd0, 0));
    vecs.push_back(mk(OP_R, 1, 1, K_F1, 0));
    vecs.push_back(mk(OP_R, 1, 2, k_dec(3'b000), 0));
    vecs.push_back(mk(OP_R, 1, 7, K_EXR, 0));
    vecs.push_back(mk(OP_R, 1, 9, K_AWB, 0));
    vecs.push_back(mk(OP_I, 1, 1, K_F1, 1));
    vecs.push_back(mk(OP_I, 1, 2, k_dec(3'b000), 1));
    vecs.push_back(mk(OP_I, 1, 8, K_EXI, 1));
    vecs.push_back(mk(OP_I, 1, 9, K_AWB, 1));
    vecs.push_back(mk(OP_LOAD, 0, 1, K_F0, 2));
    vecs.push_back(mk(OP_LOAD, 1, 1, K_F1, 2));
    vecs.push_back(mk(OP_LOAD, 1, 2, k_dec(3'b000), 2));
    vecs.push_back(mk(OP_LOAD, 1, 3, k_madr(3'b000), 2));
    vecs.push_back(mk(OP_LOAD, 0, 4, K_MRD, 2));
    vecs.push_back(mk(OP_LOAD, 0, 4, K_MRD, 2));
    vecs.push_back(mk(OP_LOAD, 0, 4, K_MRD, 2));
    vecs.push_back(mk(OP_LOAD, 1, 4, K_MRD, 2));
    vecs.push_back(mk(OP_LOAD, 1, 5, K_MWB, 2));
    vecs.push_back(mk(OP_STORE, 1, 1, K_F1, 3));
    vecs.push_back(mk(OP_STORE, 1, 2, k_dec(3'b001), 3));
    vecs.push_back(mk(OP_STORE, 1, 3, k_madr(3'b001), 3));
    vecs.push_back(mk(OP_STORE, 0, 6, K_MWR0, 3));
    vecs.push_back(mk(OP_STORE, 1, 6, K_MWR1, 3));
    vecs.push_back(mk(OP_BR, 1, 1, K_F1, 4));
    vecs.push_back(mk(OP_BR, 1, 2, k_dec(3'b010), 4));
    vecs.push_back(mk(OP_BR, 1, 10, K_BR, 4));
    vecs.push_back(mk(OP_JAL, 1, 1, K_F1, 5));
    vecs.push_back(mk(OP_JAL, 1, 2, k_dec(3'b011), 5));
    vecs.push_back(mk(OP_JAL, 1, 11, K_JAL, 5));
    vecs.push_back(mk(OP_JAL, 1, 9, K_AWB, 5));
    vecs.push_back(mk(OP_JALR, 1, 1, K_F1, 6));
    vecs.push_back(mk(OP_JALR, 1, 2, k_dec(3'b000), 6));
    vecs.push_back(mk(OP_JALR, 1, 12, K_JALR, 6));
    vecs.push_back(mk(OP_JALR, 1, 13, K_JLNK, 6));
    vecs.push_back(mk(OP_JALR, 1, 9, K_AWB, 6));
    vecs.push_back(mk(OP_LUI, 1, 1, K_F1, 7));
    vecs.push_back(mk(OP_LUI, 1, 2, k_dec(3'b100), 7));
    vecs.push_back(mk(OP_LUI, 1, 14, K_LUI, 7));
    vecs.push_back(mk(OP_BAD, 1, 1, K_F1, 8));
    vecs.push_back(mk(OP_BAD, 1, 2, k_dec(3'b000), 8));

    do_reset();
    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].rdy);
      chk($sformatf("v%0d_state", i), 32'(state_o), 32'(vecs[i].st));
      chk($sformatf("v%0d_ctl", i), 32'(act_ctl), 32'(vecs[i].ctl));
      chk($sformatf("v%0d_cnt", i), 32'(retireCount_o), 32'(vecs[i].cnt));
      tick();
    end

    // Unlisted opcode outcome
    drive(OP_BAD, 1);
`ifdef ILLEGAL_TRAP_EN
    chk("ill_state", 32'(state_o), 32'd15);
    chk("ill_flag", 32'(illegal_o), 32'd1);
    chk("ill_ctl", 32'(act_ctl), 32'd0);
`else
    chk("ill_state", 32'(state_o), 32'd1);
    chk("ill_flag", 32'(illegal_o), 32'd0);
`endif
    chk("ill_cnt", 32'(retireCount_o), 32'd8);

    // Reset during a store's ready cycle: no partial retire
    do_reset();
    drive(OP_STORE, 1); tick();
    drive(OP_STORE, 1); tick();
    drive(OP_STORE, 1); tick();
    drive(OP_STORE, 1); tick();
    drive(OP_STORE, 1);
    chk("mid_pre_state", 32'(state_o), 32'd6);
    rstN_i = 1'b0;
    #1;
    chk("mid_state", 32'(state_o), 32'd0);
    chk("mid_ret", 32'(instrRetired_o), 32'd0);
    tick();
    chk("mid_cnt", 32'(retireCount_o), 32'd0);

    // Timeout: ready on the last allowed wait cycle wins, then stuck-low traps
    do_reset();
    drive(OP_R, 0); tick();
    for (int k = 0; k < 4; k++) begin
      drive(OP_R, 0);
      chk($sformatf("tw%0d_state", k), 32'(state_o), 32'd1);
      tick();
    end
    drive(OP_R, 1); tick();
    drive(OP_R, 1);
    chk("tw_win_state", 32'(state_o), 32'd2);
    chk("tw_win_err", 32'(memErr_o), 32'd0);
    tick();
    drive(OP_R, 1); tick();
    drive(OP_R, 1); tick();
    for (int k = 0; k < 5; k++) begin
      drive(OP_R, 0);
      chk($sformatf("to%0d_state", k), 32'(state_o), 32'd1);
      chk($sformatf("to%0d_err", k), 32'(memErr_o), 32'd0);
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      drive(OP_R, (k != 0));
      chk($sformatf("trap%0d_state", k), 32'(state_o), 32'd15);
      chk($sformatf("trap%0d_err", k), 32'(memErr_o), 32'd1);
      chk($sformatf("trap%0d_ctl", k), 32'(act_ctl), 32'd0);
      tick();
    end
    chk("trap_cnt", 32'(retireCount_o), 32'd1);

    // Retire counter wrap with 17 R-type instructions
    do_reset();
    drive(OP_R, 1); tick();
    for (int i = 1; i <= 17; i++) begin
      repeat (4) begin
        drive(OP_R, 1); tick();
      end
      drive(OP_R, 1);
      chk($sformatf("wrap%0d_cnt", i), 32'(retireCount_o), 32'(i % 16));
      chk($sformatf("wrap%0d_state", i), 32'(state_o), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Multi-cycle successor to the single-cycle main decoder. It sequences each RV32I instruction (R, I-ALU, load, store, branch, JAL, JALR, LUI) over several states, sharing one ALU and one unified memory. Fetch, load and store wait on a memory ready handshake, with a parametrised timeout. It also provides a retired-instruction counter. Sits between the instruction register (opcode source) and the multicycle datapath muxes and enables.

Parameters:
CNT_W, 32, width of retireCount_o.
MEM_TIMEOUT, 15, max consecutive wait cycles with memReady_i low before trapping; 0 disables the timeout.

Ports:
clk_i  in  1  clock, rising edge
rstN_i  in  1  asynchronous active-low reset
op_i  in  7  opcode field of instruction register
memReady_i  in  1  memory completes current access this cycle
state_o  out  4  current state encoding
pcWrite_o  out  1  PC register enable
irWrite_o  out  1  instruction register enable
adrSrc_o  out  1  memory address: 0 PC, 1 ALUOut
memRead_o  out  1  memory read request
memWrite_o  out  1  memory write request
regWrite_o  out  1  register file write enable
aluSrcA_o  out  2  00 PC, 01 oldPC, 10 rs1
aluSrcB_o  out  2  00 rs2, 01 imm, 10 const 4
aluOp_o  out  2  00 add, 01 branch compare, 10 funct-decoded
resultSrc_o  out  2  00 ALUOut, 01 readData, 10 ALUResult, 11 imm
immSrc_o  out  3  000 I, 001 S, 010 B, 011 J, 100 U
branch_o  out  2  00 none, 01 cond branch, 10 JAL, 11 JALR
instrRetired_o  out  1  one-cycle pulse on instruction completion
retireCount_o  out  CNT_W  retired instruction count
memErr_o  out  1  sticky memory timeout flag
illegal_o  out  1  sticky illegal opcode flag (see optional feature)

Behaviour:
- States: IDLE 0, FETCH 1, DECODE 2, MEMADR 3, MEMREAD 4, MEMWB 5, MEMWRITE 6, EXECR 7, EXECI 8, ALUWB 9, BRANCH 10, JAL 11, JALR 12, JALRLINK 13, LUI 14, TRAP 15. Registered state; outputs are Moore from state, plus memReady_i where noted. Any output not listed for a state is 0.
- Reset: state IDLE; retireCount_o 0, memErr_o 0, illegal_o 0, wait counter 0; all strobes 0. IDLE goes to FETCH unconditionally.
- FETCH: memRead=1, adrSrc=0, aluSrcA=00, aluSrcB=10, resultSrc=10. irWrite and pcWrite equal memReady_i. Stay in FETCH until memReady_i, then go to DECODE.
- DECODE: aluSrcA=01, aluSrcB=01, aluOp=00 (branch target into ALUOut). immSrc is selected by op_i.
  - 0000011 or 0100011 go to MEMADR.
  - 0110011 goes to EXECR; 0010011 goes to EXECI.
  - 1100011 goes to BRANCH; 1101111 goes to JAL; 1100111 goes to JALR; 0110111 goes to LUI.
  - Any other opcode goes to FETCH with no retire.
- MEMADR: aluSrcA=10, aluSrcB=01; immSrc 000 for load, 001 for store. Go to MEMREAD for a load, MEMWRITE for a store.
- MEMREAD: adrSrc=1, memRead=1. Wait for memReady_i, then go to MEMWB.
- MEMWB: resultSrc=01, regWrite=1, retire, then FETCH.
- MEMWRITE: adrSrc=1, memWrite=1. Wait for memReady_i; retire in the ready cycle, then FETCH.
- EXECR: aluSrcA=10, aluSrcB=00, aluOp=10, then ALUWB.
- EXECI: aluSrcA=10, aluSrcB=01, aluOp=10, immSrc=000, then ALUWB.
- ALUWB: resultSrc=00, regWrite=1, retire, then FETCH.
- BRANCH: aluSrcA=10, aluSrcB=00, aluOp=01, resultSrc=00, branch=01, immSrc=010, retire, then FETCH.
- JAL: pcWrite=1, resultSrc=00, branch=10, aluSrcA=01, aluSrcB=10 (oldPC+4), immSrc=011, then ALUWB.
- JALR: aluSrcA=10, aluSrcB=01, resultSrc=10, pcWrite=1, branch=11, immSrc=000, then JALRLINK.
- JALRLINK: aluSrcA=01, aluSrcB=10, then ALUWB.
- LUI: immSrc=100, resultSrc=11, regWrite=1, retire, then FETCH.
- Timeout: the wait counter increments each cycle in FETCH, MEMREAD or MEMWRITE with memReady_i low, and clears on ready or on state change.
  - If MEM_TIMEOUT is nonzero and the counter reaches MEM_TIMEOUT while memReady_i is low, the next state is TRAP and memErr_o is set.
  - memReady_i high in the same cycle wins over the timeout.
- TRAP: all strobes 0; state held until reset.
- Retire: instrRetired_o is asserted in the completing cycle. retireCount_o increments on the following edge and wraps from 2^CNT_W-1 to 0.
- Reset asserted mid-instruction returns to IDLE immediately; no partial retire is counted.

Optional Feature:
ILLEGAL_TRAP_EN:
- Defined: an unlisted opcode in DECODE goes to TRAP and sets illegal_o (sticky until reset).
- Undefined: an unlisted opcode goes to FETCH (treated as NOP, no retire) and illegal_o is tied to 0.

Test Plan:
- Reset release, memReady_i=1, op_i=0110011 -> states 0,1,2,7,9,1; regWrite_o=1 in ALUWB; retireCount_o=1.
- Load with memReady_i low 3 cycles in MEMREAD -> MEMREAD held 4 cycles, then MEMWB with resultSrc_o=01, regWrite_o=1.
- MEM_TIMEOUT=4, memReady_i stuck 0 in FETCH -> TRAP after 4 wait cycles, memErr_o=1; memReady_i later rising leaves state at 15.
- JALR -> JALR state: pcWrite_o=1, branch_o=11; then JALRLINK with aluSrcA_o=01, aluSrcB_o=10; then ALUWB; retire once.
- op_i=1111111 -> with ILLEGAL_TRAP_EN: state 15, illegal_o=1; without: back to FETCH, retireCount_o unchanged.
- CNT_W=4, run 17 R-type instructions -> retireCount_o=1 after wrap.
